// File: rtl/serializer.sv
// Transmit side of the 1-bit serial link: captures a parallel word and shifts it out one strobed bit per clock.
// Optional even-parity trailer bit is enabled by defining SERIALIZER_PARITY_EN.
module serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock_100KHZ,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid_in,
    input  logic             status_in,
    output logic             ack_out,
    output logic             data_out,
    output logic             write_out,
    output logic             busy_out
);

`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CW    = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_ack;
    logic             r_data;
    logic             r_write;
    logic             r_busy;
`ifdef SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_head_data;
    logic             w_head;
    logic [WIDTH-1:0] w_shift_nxt;

    // Head bit and shifted word depend on transmit order.
    always_comb begin
        w_head_data = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
`ifdef SERIALIZER_PARITY_EN
        w_head = (r_count == CW'(WIDTH)) ? r_parity : w_head_data;
`else
        w_head = w_head_data;
`endif
    end

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
            r_data   <= 1'b0;
            r_write  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_write <= 1'b0;
                    if (data_valid_in) begin
                        r_shift  <= data_in;
                        r_count  <= '0;
                        r_ack    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= SEND;
`ifdef SERIALIZER_PARITY_EN
                        r_parity <= ^data_in;
`endif
                    end
                end
                SEND: begin
                    // Bits move only while the receiver reports ready; otherwise everything holds.
                    if (status_in) begin
                        r_data  <= w_head;
                        r_write <= 1'b1;
                        r_shift <= w_shift_nxt;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST) begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_write <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Hold off the next word until the receiver drops ready for this one.
                    r_write <= 1'b0;
                    r_data  <= 1'b0;
                    if (!status_in) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_out   = r_ack;
    assign data_out  = r_data;
    assign write_out = r_write;
    assign busy_out  = r_busy;

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer: MSB-first instance plus an LSB-first instance on shared inputs.
// Define SERIALIZER_PARITY_EN for both RTL and bench to exercise the parity trailer.
`timescale 1ns/1ps
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       status_in;
    logic       ack_out, data_out, write_out, busy_out;
    logic       ack_l, data_l, write_l, busy_l;

    int compared;
    int mismatched;
    int ack_cnt;
    int strobe_low;
    int cyc;
    bit q[$];
    bit q2[$];
    int qt[$];

    serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clock_100KHZ(clk), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .status_in(status_in), .ack_out(ack_out), .data_out(data_out), .write_out(write_out),
        .busy_out(busy_out)
    );

    serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock_100KHZ(clk), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .status_in(status_in), .ack_out(ack_l), .data_out(data_l), .write_out(write_l),
        .busy_out(busy_l)
    );

    initial clk = 1'b0;
    always #5000 clk = ~clk;

    function automatic bit exp_msb(input logic [7:0] w, input int i);
        if (i < 8) return w[7-i];
        return ^w;
    endfunction

    // One clock; sample outputs 1ns after the edge and log strobes/acks.
    task automatic step();
        bit st;
        st = status_in;
        @(posedge clk);
        #1;
        cyc++;
        if (write_out) begin
            q.push_back(data_out);
            qt.push_back(cyc);
            if (!st) strobe_low++;
        end
        if (write_l) q2.push_back(data_l);
        if (ack_out) ack_cnt++;
    endtask

    task automatic clear_log();
        q.delete();
        q2.delete();
        qt.delete();
        ack_cnt    = 0;
        strobe_low = 0;
    endtask

    task automatic push(input logic [7:0] w);
        bit got;
        got = 1'b0;
        data_in       = w;
        data_valid_in = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            if (ack_out) got = 1'b1;
        end
        data_valid_in = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL push_ack_timeout: no ack_out for word %h, required ack within 50 cycles", w);
        end
    endtask

    task automatic wait_strobes(input int n);
        for (int k = 0; k < 100 && q.size() < n; k++) step();
        if (q.size() < n) begin
            compared++; mismatched++;
            $display("FAIL strobe_timeout: got %0d strobes, required %0d", q.size(), n);
        end
    endtask

    task automatic wait_idle();
        status_in = 1'b0;
        for (int k = 0; k < 20 && busy_out; k++) step();
        if (busy_out) begin
            compared++; mismatched++;
            $display("FAIL idle_timeout: busy_out=%b, required 0", busy_out);
        end
        status_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_in = '0; data_valid_in = 1'b0; status_in = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        compared++;
        if ({ack_out, data_out, write_out, busy_out} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b, required 0000", {ack_out, data_out, write_out, busy_out});
        end
    endtask

    task automatic test_basic();
        int busy_low;
        logic [7:0] w;
        w = 8'hA5;
        busy_low = 0;
        clear_log();
        status_in = 1'b1;
        push(w);
        compared++;
        if (ack_cnt !== 1) begin mismatched++; $display("FAIL basic_ack: got %0d acks, required 1", ack_cnt); end
        for (int k = 0; k < NB + 3; k++) begin
            step();
            if (!busy_out) busy_low++;
        end
        compared++;
        if (q.size() !== NB) begin mismatched++; $display("FAIL basic_count: got %0d strobes, required %0d", q.size(), NB); end
        for (int i = 0; i < NB && i < q.size(); i++) begin
            compared++;
            if (q[i] !== exp_msb(w, i)) begin mismatched++; $display("FAIL basic_bit%0d: got %b, required %b", i, q[i], exp_msb(w, i)); end
        end
        compared++;
        if (qt.size() == NB && (qt[NB-1] - qt[0]) !== NB - 1) begin
            mismatched++; $display("FAIL basic_consecutive: span %0d, required %0d", qt[NB-1] - qt[0], NB - 1);
        end
        compared++;
        if (busy_low !== 0) begin mismatched++; $display("FAIL basic_busy: busy_out low %0d cycles, required 0", busy_low); end
        compared++;
        if (ack_cnt !== 1) begin mismatched++; $display("FAIL basic_ack_once: got %0d acks, required 1", ack_cnt); end
        status_in = 1'b0;
        step(); step();
        compared++;
        if ({busy_out, write_out, data_out} !== 3'b000) begin
            mismatched++; $display("FAIL basic_idle: busy/write/data=%b, required 000", {busy_out, write_out, data_out});
        end
        status_in = 1'b1;
    endtask

    task automatic test_stall();
        logic [7:0] w;
        int low_cycles;
        w = 8'h3C;
        low_cycles = 0;
        clear_log();
        status_in = 1'b1;
        push(w);
        wait_strobes(3);
        status_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!write_out) low_cycles++;
        end
        compared++;
        if (low_cycles !== 4 || q.size() !== 3) begin
            mismatched++; $display("FAIL stall_hold: low=%0d strobes=%0d, required low=4 strobes=3", low_cycles, q.size());
        end
        status_in = 1'b1;
        wait_strobes(NB);
        step(); step();
        compared++;
        if (q.size() !== NB) begin mismatched++; $display("FAIL stall_count: got %0d strobes, required %0d", q.size(), NB); end
        for (int i = 0; i < NB && i < q.size(); i++) begin
            compared++;
            if (q[i] !== exp_msb(w, i)) begin mismatched++; $display("FAIL stall_bit%0d: got %b, required %b", i, q[i], exp_msb(w, i)); end
        end
        compared++;
        if (strobe_low !== 0) begin mismatched++; $display("FAIL stall_strobe_low: %0d strobes while not ready, required 0", strobe_low); end
        wait_idle();
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        w = 8'h81;
        clear_log();
        status_in = 1'b1;
        push(8'hFF);
        wait_strobes(5);
        reset = 1'b1;
        #1;
        compared++;
        if ({ack_out, data_out, write_out, busy_out} !== 4'b0000) begin
            mismatched++; $display("FAIL midreset_outputs: got %b, required 0000", {ack_out, data_out, write_out, busy_out});
        end
        step();
        reset = 1'b0;
        step(); step();
        compared++;
        if (q.size() !== 5 || busy_out !== 1'b0) begin
            mismatched++; $display("FAIL midreset_quiet: strobes=%0d busy=%b, required 5 and 0", q.size(), busy_out);
        end
        clear_log();
        push(w);
        wait_strobes(NB);
        step(); step();
        compared++;
        if (q.size() !== NB) begin mismatched++; $display("FAIL midreset_count: got %0d strobes, required %0d", q.size(), NB); end
        for (int i = 0; i < NB && i < q.size(); i++) begin
            compared++;
            if (q[i] !== exp_msb(w, i)) begin mismatched++; $display("FAIL midreset_bit%0d: got %b, required %b", i, q[i], exp_msb(w, i)); end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        w2 = 8'h34;
        clear_log();
        status_in = 1'b1;
        push(8'h12);
        data_in       = w2;
        data_valid_in = 1'b1;
        wait_strobes(NB);
        for (int k = 0; k < 5; k++) step();
        compared++;
        if (ack_cnt !== 1 || q.size() !== NB) begin
            mismatched++; $display("FAIL b2b_hold: acks=%0d strobes=%0d, required 1 and %0d", ack_cnt, q.size(), NB);
        end
        status_in = 1'b0;
        for (int k = 0; k < 5 && ack_cnt < 2; k++) step();
        data_valid_in = 1'b0;
        step(); step();
        compared++;
        if (ack_cnt !== 2 || q.size() !== NB) begin
            mismatched++; $display("FAIL b2b_second_ack: acks=%0d strobes=%0d, required 2 and %0d", ack_cnt, q.size(), NB);
        end
        status_in = 1'b1;
        wait_strobes(2 * NB);
        step(); step();
        compared++;
        if (q.size() !== 2 * NB || ack_cnt !== 2) begin
            mismatched++; $display("FAIL b2b_total: strobes=%0d acks=%0d, required %0d and 2", q.size(), ack_cnt, 2 * NB);
        end
        for (int i = 0; i < 8 && NB + i < q.size(); i++) begin
            compared++;
            if (q[NB+i] !== w2[7-i]) begin mismatched++; $display("FAIL b2b_bit%0d: got %b, required %b", i, q[NB+i], w2[7-i]); end
        end
        compared++;
        if (strobe_low !== 0) begin mismatched++; $display("FAIL b2b_strobe_low: %0d strobes while not ready, required 0", strobe_low); end
        wait_idle();
    endtask

    task automatic test_loopback();
        logic [7:0] words [3];
        logic [7:0] rx, rx2;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            clear_log();
            push(words[n]);
            wait_strobes(NB);
            step();
            rx = '0; rx2 = '0;
            for (int i = 0; i < 8 && i < q.size(); i++) rx = {rx[6:0], q[i]};
            for (int i = 0; i < 8 && i < q2.size(); i++) rx2 = {q2[i], rx2[7:1]};
            compared++;
            if (rx !== words[n]) begin mismatched++; $display("FAIL loop_msb%0d: got %h, required %h", n, rx, words[n]); end
            compared++;
            if (rx2 !== words[n]) begin mismatched++; $display("FAIL loop_lsb%0d: got %h, required %h", n, rx2, words[n]); end
            wait_idle();
        end
        clear_log();
        push(8'hA5);
        wait_strobes(NB);
        step();
        begin
            bit lsb_seq [8];
            lsb_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            compared++;
            if (q2.size() < 8) begin
                mismatched++; $display("FAIL lsb_a5_count: got %0d strobes, required >= 8", q2.size());
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (q2[i] !== lsb_seq[i]) begin
                        mismatched++; $display("FAIL lsb_a5_bit%0d: got %b, required %b", i, q2[i], lsb_seq[i]);
                        break;
                    end
                end
            end
        end
        wait_idle();
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        bit         par   [2];
        words[0] = 8'hA5; par[0] = 1'b0;
        words[1] = 8'h07; par[1] = 1'b1;
        for (int n = 0; n < 2; n++) begin
            clear_log();
            push(words[n]);
            wait_strobes(9);
            step(); step();
            compared++;
            if (q.size() !== 9) begin
                mismatched++; $display("FAIL parity_count%0d: got %0d strobes, required 9", n, q.size());
            end else if (q[8] !== par[n]) begin
                mismatched++; $display("FAIL parity_bit%0d: got %b, required %b", n, q[8], par[n]);
            end
            wait_idle();
        end
    endtask
`endif

    initial begin
        compared = 0; mismatched = 0; cyc = 0;
        clear_log();
        test_reset();
        test_basic();
        test_stall();
        test_reset_midword();
        test_back_to_back();
        test_loopback();
`ifdef SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
